// File: rtl/instr_fetch.sv
// instr_fetch: multi-cycle fetch stage feeding decode.
// Split addr/data bus handshake, AdEL check, flush with response drain.
module instr_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_ready,
  input  logic                  flush,
  output logic                  ibus_valid,
  output logic [ADDR_WIDTH-1:0] ibus_addr,
  input  logic                  ibus_addr_ok,
  input  logic                  ibus_data_ok,
  input  logic [DATA_WIDTH-1:0] ibus_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_ex,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;

  // Handshake outputs are pure state decodes, so no input reaches them.
  assign fetch_ready = (state == S_IDLE);
  assign ibus_valid  = (state == S_ADDR);
  assign out_valid   = (state == S_DONE);
  assign ibus_addr   = pc_q;
  assign out_pc      = pc_q;

  // Fetch FSM: request latch, bus handshake, result hold, drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      out_instr   <= '0;
      out_ex      <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fetch_valid) begin
            pc_q <= fetch_pc;
            if (fetch_pc[1:0] != 2'b00) begin
              out_ex    <= 1'b1;
              out_instr <= '0;
              state     <= S_DONE;
            end else begin
              out_ex <= 1'b0;
              state  <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (flush) begin
            // An accepted address with no data yet leaves a response owed.
            if (ibus_addr_ok && !ibus_data_ok)
              state <= S_DRAIN;
            else
              state <= S_IDLE;
          end else if (ibus_addr_ok) begin
            if (ibus_data_ok) begin
              out_instr <= ibus_data;
              state     <= S_DONE;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (ibus_data_ok) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              out_instr <= ibus_data;
              state     <= S_DONE;
            end
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ibus_data_ok)
            state <= S_IDLE;
        end
        S_DONE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (out_ready) begin
            fetch_count <= fetch_count + 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors plus flush/drain/wrap sequences.
// Counter width shrunk to 4 so wraparound is reachable quickly.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic        ibus_valid;
  logic [31:0] ibus_addr;
  logic        ibus_addr_ok;
  logic        ibus_data_ok;
  logic [31:0] ibus_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ex;
  logic [3:0]  fetch_count;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  cnt_model = '0;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .ibus_valid  (ibus_valid),
    .ibus_addr   (ibus_addr),
    .ibus_addr_ok(ibus_addr_ok),
    .ibus_data_ok(ibus_data_ok),
    .ibus_data   (ibus_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ex      (out_ex),
    .fetch_count (fetch_count)
  );

  typedef struct {
    logic [31:0] pc;
    int          adly;
    int          ddly;
    logic [31:0] data;
    int          hold;
    logic [31:0] ei;
    logic        ee;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int adly,
                          input int ddly, input logic [31:0] data,
                          input int hold, input logic [31:0] ei,
                          input logic ee);
    chk("fetch_ready_idle", {31'b0, fetch_ready}, 1);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    @(negedge clk);
    fetch_valid = 1'b0;
    if (!ee) begin
      for (int i = 0; i < adly; i++) begin
        chk("ibus_valid_wait", {31'b0, ibus_valid}, 1);
        chk("ibus_addr_wait", ibus_addr, pc);
        @(negedge clk);
      end
      chk("ibus_valid_ack", {31'b0, ibus_valid}, 1);
      chk("ibus_addr_ack", ibus_addr, pc);
      ibus_addr_ok = 1'b1;
      ibus_data_ok = (ddly == 0);
      ibus_data    = (ddly == 0) ? data : 32'hffff_ffff;
      @(negedge clk);
      ibus_addr_ok = 1'b0;
      ibus_data_ok = 1'b0;
      if (ddly > 0) begin
        for (int i = 1; i < ddly; i++) begin
          chk("ibus_valid_data", {31'b0, ibus_valid}, 0);
          chk("out_valid_data", {31'b0, out_valid}, 0);
          @(negedge clk);
        end
        chk("ibus_valid_data", {31'b0, ibus_valid}, 0);
        ibus_data_ok = 1'b1;
        ibus_data    = data;
        @(negedge clk);
        ibus_data_ok = 1'b0;
        ibus_data    = 32'h0;
      end
    end
    for (int i = 0; i <= hold; i++) begin
      chk("out_valid", {31'b0, out_valid}, 1);
      chk("ibus_valid_done", {31'b0, ibus_valid}, 0);
      chk("out_instr", out_instr, ei);
      chk("out_pc", out_pc, pc);
      chk("out_ex", {31'b0, out_ex}, {31'b0, ee});
      if (i < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cnt_model = cnt_model + 1'b1;
    chk("fetch_ready_after", {31'b0, fetch_ready}, 1);
    chk("out_valid_after", {31'b0, out_valid}, 0);
    chk("fetch_count", {28'b0, fetch_count}, {28'b0, cnt_model});
  endtask

  initial begin
    vecs[0] = '{32'hbfc00000, 0, 0, 32'h24080001, 0, 32'h24080001, 1'b0};
    vecs[1] = '{32'hbfc00002, 0, 0, 32'h11111111, 0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h00001000, 3, 2, 32'h8c020004, 0, 32'h8c020004, 1'b0};
    vecs[3] = '{32'h00000004, 1, 1, 32'h12345678, 5, 32'h12345678, 1'b0};
    vecs[4] = '{32'h00000001, 0, 0, 32'h22222222, 2, 32'h00000000, 1'b1};
    vecs[5] = '{32'h80000010, 0, 3, 32'h00000000, 1, 32'h00000000, 1'b0};

    resetn       = 1'b0;
    fetch_valid  = 1'b0;
    fetch_pc     = '0;
    flush        = 1'b0;
    ibus_addr_ok = 1'b0;
    ibus_data_ok = 1'b0;
    ibus_data    = '0;
    out_ready    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 1);
    chk("rst_ibus_valid", {31'b0, ibus_valid}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ex", {31'b0, out_ex}, 0);
    chk("rst_fetch_count", {28'b0, fetch_count}, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      do_fetch(vecs[v].pc, vecs[v].adly, vecs[v].ddly, vecs[v].data,
               vecs[v].hold, vecs[v].ei, vecs[v].ee);

    // flush in DATA, stale response drained, new fetch clean
    fetch_valid = 1'b1;
    fetch_pc    = 32'h00000100;
    @(negedge clk);
    fetch_valid  = 1'b0;
    ibus_addr_ok = 1'b1;
    @(negedge clk);
    ibus_addr_ok = 1'b0;
    flush        = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_fetch_ready", {31'b0, fetch_ready}, 0);
    chk("drain_ibus_valid", {31'b0, ibus_valid}, 0);
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_pc    = 32'h80000000;
    @(negedge clk);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    chk("drain_flush_ignored", {31'b0, fetch_ready}, 0);
    chk("drain_out_valid", {31'b0, out_valid}, 0);
    ibus_data_ok = 1'b1;
    ibus_data    = 32'hdeadbeef;
    @(negedge clk);
    ibus_data_ok = 1'b0;
    ibus_data    = '0;
    chk("drained_fetch_ready", {31'b0, fetch_ready}, 1);
    chk("drained_out_valid", {31'b0, out_valid}, 0);
    do_fetch(32'h80000000, 0, 0, 32'h3c1d8001, 0, 32'h3c1d8001, 1'b0);

    // flush in ADDR without addr_ok: request withdrawn
    fetch_valid = 1'b1;
    fetch_pc    = 32'h00000300;
    @(negedge clk);
    fetch_valid = 1'b0;
    flush       = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("addr_flush_ready", {31'b0, fetch_ready}, 1);
    chk("addr_flush_ibus", {31'b0, ibus_valid}, 0);

    // flush in ADDR with addr_ok: response owed, drain
    fetch_valid = 1'b1;
    fetch_pc    = 32'h00000304;
    @(negedge clk);
    fetch_valid  = 1'b0;
    flush        = 1'b1;
    ibus_addr_ok = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    ibus_addr_ok = 1'b0;
    chk("addr_ack_flush_drain", {31'b0, fetch_ready}, 0);
    ibus_data_ok = 1'b1;
    ibus_data    = 32'hcafef00d;
    @(negedge clk);
    ibus_data_ok = 1'b0;
    chk("addr_ack_flush_idle", {31'b0, fetch_ready}, 1);
    chk("addr_ack_flush_noout", {31'b0, out_valid}, 0);

    // flush beats out_ready in DONE
    fetch_valid = 1'b1;
    fetch_pc    = 32'h00000402;
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("done_flush_valid", {31'b0, out_valid}, 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("done_flush_idle", {31'b0, fetch_ready}, 1);
    chk("done_flush_count", {28'b0, fetch_count}, {28'b0, cnt_model});

    // run counter up to all-ones, then wrap
    for (int n = 0; n < 16 && cnt_model != 4'hf; n++)
      do_fetch(32'h00000003, 0, 0, 32'h0, 0, 32'h0, 1'b1);
    chk("count_max", {28'b0, fetch_count}, 32'hf);
    do_fetch(32'h00000008, 0, 0, 32'h00400020, 0, 32'h00400020, 1'b0);
    chk("count_wrap", {28'b0, fetch_count}, 0);

    // asynchronous reset mid-fetch
    fetch_valid = 1'b1;
    fetch_pc    = 32'h00000200;
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("pre_reset_ibus", {31'b0, ibus_valid}, 1);
    do_fetch_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic do_fetch_reset();
    resetn = 1'b0;
    #1;
    cnt_model = '0;
    chk("arst_ibus_valid", {31'b0, ibus_valid}, 0);
    chk("arst_fetch_ready", {31'b0, fetch_ready}, 1);
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_out_pc", out_pc, 0);
    chk("arst_count", {28'b0, fetch_count}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, fetch_ready}, 1);
  endtask

endmodule
